// File: rtl/debounce_multi_if.sv
// debounce_multi_if: pin and pulse bundle between the switch pins and the debouncer
// Ports: i_switch raw pins toward the debouncer; o_switch/o_rise/o_fall/o_long/o_repeat back from it
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_switch;
  logic [N_CH-1:0] o_switch;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_long;
  logic [N_CH-1:0] o_repeat;
  modport master (output i_switch, input o_switch, o_rise, o_fall, o_long, o_repeat);
  modport slave (input i_switch, output o_switch, o_rise, o_fall, o_long, o_repeat);
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, debouncer, edge pulses, long-press and auto-repeat pulses
// Ports: clk; RESET async active-low; bus.i_switch raw pins; bus.o_switch debounced level (1 = pressed);
//        bus.o_rise/o_fall one-cycle edge pulses; bus.o_long long-press pulse; bus.o_repeat auto-repeat pulses
module debounce_multi #(
  parameter int N_CH           = 4,
  parameter int DEBOUNCE_LIMIT = 125,
  parameter int CNT_W          = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTIVE_LOW     = 0,
  parameter int LONG_LIMIT     = 125000,
  parameter int REPEAT_PERIOD  = 0,
  parameter int HOLD_W         = 24
) (
  input logic clk,
  input logic RESET,
  debounce_multi_if.slave bus
);
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic REP_EN = REPEAT_PERIOD > 0;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_LIMIT - 1);
  localparam logic [HOLD_W-1:0] LONG_SAT = HOLD_W'(LONG_LIMIT);
  localparam logic [HOLD_W-1:0] REP_MAX = HOLD_W'(REP_EN ? REPEAT_PERIOD - 1 : 0);
  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [SYNC_STAGES-1:0] sync_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];
  logic [N_CH-1:0] sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
  logic [N_CH-1:0] long_q, long_d, rep_q, rep_d, done_q, done_d;
  logic [N_CH-1:0] s, chg, db_hit, h_hit, idle, live;
  always_comb begin
    sync_d = sync_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    {s, chg, db_hit, h_hit, idle, live} = '0;
    {sw_d, rise_d, fall_d, long_d, rep_d, done_d} = '0;
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.i_switch[i]};
      s[i] = sync_q[i][SYNC_STAGES-1] ^ POL;
      chg[i] = s[i] != sw_q[i];
      db_hit[i] = cnt_q[i] == DB_MAX;
      cnt_d[i] = chg[i] && !db_hit[i] ? cnt_q[i] + 1'b1 : '0;
      sw_d[i] = chg[i] && db_hit[i] ? s[i] : sw_q[i];
      rise_d[i] = chg[i] && db_hit[i] && s[i];
      fall_d[i] = chg[i] && db_hit[i] && !s[i];
      // idle: released or releasing this edge, so the hold machinery is parked at zero
      idle[i] = !sw_q[i] || fall_d[i];
      // a release already visible at the synchroniser output mutes long/repeat pulses
      // while the debounce of that release is still in progress
      live[i] = !idle[i] && s[i];
      // hold target is LONG_LIMIT-1 before the long press, REPEAT_PERIOD-1 afterwards;
      // the counter reloads on a hit even when the pulse itself is muted
      h_hit[i] = !idle[i] && hold_q[i] == (done_q[i] ? REP_MAX : LONG_MAX);
      hold_d[i] = idle[i] || (h_hit[i] && REP_EN) ? '0 :
                  !REP_EN && hold_q[i] == LONG_SAT ? hold_q[i] : hold_q[i] + 1'b1;
      done_d[i] = !idle[i] && (done_q[i] || h_hit[i]);
      long_d[i] = live[i] && h_hit[i] && !done_q[i];
      rep_d[i] = REP_EN && live[i] && h_hit[i] && done_q[i];
    end
  end
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{POL}};
        cnt_q[i] <= '0;
        hold_q[i] <= '0;
      end
      {sw_q, rise_q, fall_q, long_q, rep_q, done_q} <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      {sw_q, rise_q, fall_q, long_q, rep_q, done_q} <= {sw_d, rise_d, fall_d, long_d, rep_d, done_d};
    end
  end
  assign bus.o_switch = sw_q;
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;
  assign bus.o_long = long_q;
  assign bus.o_repeat = rep_q;
endmodule
